// File: rtl/rv32i_types.sv
// Shared RV32I type definitions for the memory stage.
//   lsu_state_t    : load/store unit handshake states
//   load_funct3_t  : funct3 encodings of the load instructions
//   store_funct3_t : funct3 encodings of the store instructions
//   store_format() : moves store data onto its byte lanes
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // Byte and halfword stores are shifted onto their lanes. Any bytes pushed
  // past bit 31 (halfword at offset 3) are simply lost. Words and undefined
  // codes pass through unshifted.
  function automatic logic [31:0] store_format(input logic [2:0]  funct3,
                                               input logic [1:0]  bit_shift,
                                               input logic [31:0] store_data);
    logic [31:0] result;
    case (funct3)
      SB, SH:  result = store_data << {bit_shift, 3'b000};
      default: result = store_data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_load_store_unit_load_formatter.sv
// Combinational load-data formatter.
//   dmem_rdata : raw 32-bit word returned by data memory
//   bit_shift  : byte offset of the access within the word
//   funct3     : load width / signedness code
//   formatted  : shifted and sign/zero-extended load result
module load_formatter
  import rv32i_types::*;
(
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  bit_shift,
  input  logic [2:0]  funct3,
  output logic [31:0] formatted
);

  // Only the low halfword of the shifted word is ever consumed. For a
  // halfword at offset 3 the upper byte comes back as zero before extension.
  logic [15:0] shifted;

  always_comb begin
    shifted = 16'(dmem_rdata >> {bit_shift, 3'b000});
    case (funct3)
      LB:      formatted = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     formatted = {24'b0, shifted[7:0]};
      LH:      formatted = {{16{shifted[15]}}, shifted};
      LHU:     formatted = {16'b0, shifted};
      default: formatted = dmem_rdata;  // lw and undefined codes: raw word
    endcase
  end

endmodule

// File: rtl/dmem_load_store_unit.sv
// Memory-stage load/store unit between EX/MEM and the data memory.
// Accepts one memory op from EX/MEM, issues a registered request to the
// memory and holds the pipeline with stall until the response arrives. Load
// data is formatted and presented for one cycle with load_valid.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/is_load/is_store: EX/MEM op qualifiers
//   funct3, bit_shift         : access width code and byte offset
//   addr_aligned, byte_enable, store_data : request contents
//   dmem_*                    : registered memory request / response port
//   load_data, load_valid     : formatted load result and its strobe
//   stall                     : combinational pipeline freeze
module dmem_load_store_unit
  import rv32i_types::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [WORD_W-1:0] addr_aligned,
  input  logic [1:0]        bit_shift,
  input  logic [3:0]        byte_enable,
  input  logic [WORD_W-1:0] store_data,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [WORD_W-1:0] dmem_address,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_mbe,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic [WORD_W-1:0] load_data,
  output logic              load_valid,
  output logic              stall
);

  lsu_state_t        state_q, state_d;
  logic              is_load_q;
  logic [2:0]        funct3_q;
  logic [1:0]        bit_shift_q;
  logic              dmem_read_q, dmem_write_q;
  logic [WORD_W-1:0] dmem_address_q, dmem_wdata_q, load_data_q;
  logic [3:0]        dmem_mbe_q;
  logic              load_valid_q;
  logic              accept;
  logic [31:0]       formatted;

  load_formatter u_load_formatter (
    .dmem_rdata (dmem_rdata),
    .bit_shift  (bit_shift_q),
    .funct3     (funct3_q),
    .formatted  (formatted)
  );

  assign accept = req_valid & (is_load | is_store);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_resp) state_d = DONE;
      end
      // req_valid still shows the finished op here, so it is not sampled.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      is_load_q      <= 1'b0;
      funct3_q       <= 3'b0;
      bit_shift_q    <= 2'b0;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_address_q <= '0;
      dmem_wdata_q   <= '0;
      dmem_mbe_q     <= 4'b0;
      load_data_q    <= '0;
      load_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            // A load wins when both qualifiers are set.
            is_load_q      <= is_load;
            funct3_q       <= funct3;
            bit_shift_q    <= bit_shift;
            dmem_read_q    <= is_load;
            dmem_write_q   <= ~is_load;
            dmem_address_q <= addr_aligned;
            dmem_wdata_q   <= is_load ? '0 : store_format(funct3, bit_shift, store_data);
            dmem_mbe_q     <= is_load ? 4'b1111 : byte_enable;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            if (is_load_q) begin
              load_data_q  <= formatted;
              load_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_read    = dmem_read_q;
  assign dmem_write   = dmem_write_q;
  assign dmem_address = dmem_address_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_mbe     = dmem_mbe_q;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;

endmodule

// File: tb/tb_dmem_load_store_unit.sv
module tb_dmem_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr_aligned;
  logic [1:0]  bit_shift;
  logic [3:0]  byte_enable;
  logic [31:0] store_data;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;

  int checks = 0;
  int errors = 0;

  // {read, write, address, wdata, mbe}
  typedef logic [69:0] req_t;
  req_t        exp_req_q[$];
  logic [31:0] exp_load_q[$];

  always #5 clk = ~clk;

  dmem_load_store_unit #(.WORD_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .is_load      (is_load),
    .is_store     (is_store),
    .funct3       (funct3),
    .addr_aligned (addr_aligned),
    .bit_shift    (bit_shift),
    .byte_enable  (byte_enable),
    .store_data   (store_data),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_mbe     (dmem_mbe),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .stall        (stall)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load result: pick bytes from the word by position, then apply
  // the width/sign rule with integer arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int sh, input logic [31:0] rd);
    int unsigned v;
    int signed   r;
    v = 0;
    for (int j = 0; j < 4; j++)
      if (sh + j < 4) v += ((rd >> (8 * (sh + j))) & 32'hFF) << (8 * j);
    case (f3)
      3'b000: begin r = int'(v % 256);   if (r >= 128)   r -= 256;   return 32'(r); end
      3'b100: return v % 256;
      3'b001: begin r = int'(v % 65536); if (r >= 32768) r -= 65536; return 32'(r); end
      3'b101: return v % 65536;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input int sh, input logic [31:0] sd);
    longint unsigned p;
    if (f3 == 3'b010) return sd;
    p = longint'(sd) * (64'd1 << (8 * sh));
    return p[31:0];
  endfunction

  // Monitor: every newly raised request is popped from the scoreboard; while
  // the strobe stays up the request must not change; each load_valid pops
  // the next expected load result.
  initial begin
    logic active, prev_active;
    req_t cur, held;
    prev_active = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_active = 1'b0;
      end else begin
        active = dmem_read | dmem_write;
        cur = {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe};
        if (active && !prev_active) begin
          if (exp_req_q.size() == 0) chk("unexpected_request", 72'(cur), 72'h0);
          else chk("request", 72'(cur), 72'(exp_req_q.pop_front()));
        end else if (active) begin
          chk("request_held", 72'(cur), 72'(held));
        end
        if (load_valid) begin
          if (exp_load_q.size() == 0) chk("unexpected_load_valid", 72'(load_data), 72'h0);
          else chk("load_data", 72'(load_data), 72'(exp_load_q.pop_front()));
        end
        prev_active = active;
        held = cur;
      end
    end
  end

  // Issue one op from IDLE (called at posedge+1), answer after `delay` extra
  // BUSY cycles, finish at posedge+1 with the unit back in IDLE.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [1:0] sh,
                       input logic [3:0] be, input logic [31:0] sd, input logic [31:0] addr,
                       input int delay, input logic [31:0] rd);
    logic eff_load;
    eff_load = ld;
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; bit_shift = sh;
    byte_enable = be; store_data = sd; addr_aligned = addr;
    exp_req_q.push_back({eff_load, ~eff_load, addr,
                         eff_load ? 32'h0 : model_wdata(f3, int'(sh), sd),
                         eff_load ? 4'hF : be});
    @(negedge clk); chk("stall_accept", 72'(stall), 72'd1);
    @(posedge clk); #1;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("stall_busy", 72'(stall), 72'd1);
      chk("strobe_busy", 72'({dmem_read, dmem_write}), 72'({eff_load, ~eff_load}));
      @(posedge clk); #1;
    end
    dmem_resp = 1'b1; dmem_rdata = rd;
    if (eff_load) exp_load_q.push_back(model_load(f3, int'(sh), rd));
    @(negedge clk); chk("stall_resp", 72'(stall), 72'd1);
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    chk("stall_done", 72'(stall), 72'd0);
    chk("load_valid_done", 72'(load_valid), 72'(eff_load));
    chk("strobes_done", 72'({dmem_read, dmem_write}), 72'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] saved;
    logic [2:0]  ld_codes [8];
    logic [2:0]  st_codes [3];
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    st_codes = '{3'b000, 3'b001, 3'b010};

    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
    addr_aligned = '0; bit_shift = '0; byte_enable = '0; store_data = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b1; is_load = 1'b1;   // stall must stay low under reset
    @(negedge clk);
    chk("reset_stall", 72'(stall), 72'd0);
    chk("reset_outputs", 72'({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe, load_data, load_valid}), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; is_load = 1'b0;

    // lb at offset 2, response after 2 wait cycles
    do_op(1'b1, 1'b0, 3'b000, 2'd2, 4'h0, 32'h0, 32'h0000_1000, 2, 32'h0080_1234);
    chk("lb_example", 72'(load_data), 72'hFFFF_FF80);
    // lhu and lw with the same word
    do_op(1'b1, 1'b0, 3'b101, 2'd2, 4'h0, 32'h0, 32'h0000_2000, 0, 32'h8001_5555);
    chk("lhu_example", 72'(load_data), 72'h0000_8001);
    do_op(1'b1, 1'b0, 3'b010, 2'd0, 4'h0, 32'h0, 32'h0000_2000, 0, 32'h8001_5555);
    chk("lw_example", 72'(load_data), 72'h8001_5555);
    // sb at offset 1, address held over several wait cycles
    do_op(1'b0, 1'b1, 3'b000, 2'd1, 4'b0010, 32'h0000_00AB, 32'h0000_3004, 3, 32'h0);
    chk("sb_load_data_kept", 72'(load_data), 72'h8001_5555);
    // misaligned halfword at offset 3
    do_op(1'b0, 1'b1, 3'b001, 2'd3, 4'b1000, 32'h0000_C3D4, 32'h0000_4000, 0, 32'h0);
    do_op(1'b1, 1'b0, 3'b001, 2'd3, 4'h0, 32'h0, 32'h0000_4000, 0, 32'hF2FF_FFFF);
    chk("lh_offset3", 72'(load_data), 72'h0000_00F2);
    // load and store both set behaves as a load
    do_op(1'b1, 1'b1, 3'b100, 2'd1, 4'hF, 32'hFFFF_FFFF, 32'h0000_5000, 1, 32'h1234_9A78);
    // back-to-back load then store with 1-cycle responses
    do_op(1'b1, 1'b0, 3'b000, 2'd3, 4'h0, 32'h0, 32'h0000_6000, 0, 32'h7F00_0000);
    do_op(1'b0, 1'b1, 3'b010, 2'd0, 4'hF, 32'hDEAD_BEEF, 32'h0000_6004, 0, 32'h0);

    // reset while a load is outstanding
    saved = load_data;
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; bit_shift = 2'd0;
    addr_aligned = 32'h0000_7000;
    exp_req_q.push_back({1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF});
    @(posedge clk); #1;
    @(negedge clk); chk("abort_busy_read", 72'(dmem_read), 72'd1);
    @(posedge clk); #1 rst = 1'b1; req_valid = 1'b0;
    @(negedge clk); chk("abort_stall_in_rst", 72'(stall), 72'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_read_cleared", 72'(dmem_read), 72'd0);
    chk("abort_stall", 72'(stall), 72'd0);
    chk("abort_load_data_cleared", 72'({load_data, load_valid}), 72'(33'd0));
    // late / spurious response in IDLE is ignored
    @(posedge clk); #1 dmem_resp = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
    @(negedge clk); chk("spurious_stall", 72'(stall), 72'd0);
    @(posedge clk); #1 dmem_resp = 1'b0;
    @(negedge clk);
    chk("spurious_ignored", 72'({load_valid, dmem_read, dmem_write, load_data}), 72'd0);
    if (saved == 32'h0) chk("abort_prior_data_nonzero", 72'(saved), 72'd1);
    @(posedge clk); #1;

    // randomized ops
    for (int n = 0; n < 80; n++) begin
      logic ld;
      logic [2:0] f3;
      ld = $urandom_range(0, 1) == 1;
      f3 = ld ? ld_codes[$urandom_range(0, 7)] : st_codes[$urandom_range(0, 2)];
      do_op(ld, ld ? ($urandom_range(0, 3) == 0) : 1'b1, f3, 2'($urandom_range(0, 3)),
            4'($urandom), $urandom, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_req_drained", 72'(exp_req_q.size()), 72'd0);
    chk("scoreboard_load_drained", 72'(exp_load_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_load_store_unit.md
Name: dmem_load_store_unit

Overview:
- Memory-stage responder that consumes the EX/MEM memory request: aligned address, byte shift, byte enable and store data.
- Drives the data-memory port with a request/response handshake and holds the pipeline with a stall until the memory responds.
- Returns load data that is extracted, shifted and sign- or zero-extended, ready for the MEM/WB register.
- Sits between the EX/MEM pipeline register and the data cache/memory.

Parameters:
- WORD_W, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  EX/MEM holds a valid instruction this cycle
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- funct3  in  3  load/store width code (rv32i_types)
- addr_aligned  in  32  word-aligned address, bits [1:0] = 00
- bit_shift  in  2  original address bits [1:0]
- byte_enable  in  4  store byte mask from EX/MEM
- store_data  in  32  unshifted rs2 value
- dmem_read  out  1  memory read request
- dmem_write  out  1  memory write request
- dmem_address  out  32  request address
- dmem_wdata  out  32  lane-shifted store data
- dmem_mbe  out  4  byte enable toward memory
- dmem_rdata  in  32  memory read data
- dmem_resp  in  1  one-cycle response pulse
- load_data  out  32  formatted load result
- load_valid  out  1  one-cycle pulse when load_data is updated
- stall  out  1  freeze the upstream pipeline registers

Behaviour:
- One clock domain (clk); rst is synchronous, active-high.
- Reset:
  - State goes to IDLE.
  - dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe, load_data and load_valid are all 0.
  - stall is 0 while rst is high.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If req_valid and (is_load or is_store): stall = 1 combinationally; latch the request; go to BUSY.
  - The dmem_read/dmem_write strobe rises on the same edge, so the request is registered.
  - Otherwise stall = 0 and all strobes stay 0.
- BUSY:
  - stall = 1.
  - dmem_read/dmem_write, dmem_address, dmem_wdata and dmem_mbe are held constant until dmem_resp.
  - On dmem_resp: strobes drop on that edge; for a load, load_data is captured and load_valid pulses the next cycle; go to DONE.
- DONE:
  - stall = 0, so the pipeline advances; load_valid = 1 only if the op was a load.
  - req_valid is ignored in DONE because it still shows the completed op.
  - Unconditionally go to IDLE.
- Latency: request issued 1 cycle after acceptance; minimum 3 cycles per op with a 1-cycle memory response.
- A new op cannot be accepted in the cycle immediately after DONE's stall release except through IDLE.
- is_load and is_store both high: treated as a load.
- dmem_resp in IDLE or DONE: ignored.
- Reset mid-op: abort to IDLE; strobes are 0 after the reset edge; no load_valid is generated.
- Store formatting, by funct3:
  - sb (000): dmem_wdata = store_data << (8*bit_shift).
  - sh (001): dmem_wdata = store_data << (8*bit_shift).
  - sw (010): dmem_wdata = store_data, unshifted.
  - dmem_mbe = byte_enable.
- Load requests: dmem_mbe = 4'b1111 and dmem_wdata = 0.
- Load formatting: sh = dmem_rdata >> (8*bit_shift), then by funct3:
  - lb (000): sign-extend sh[7:0].
  - lbu (100): zero-extend sh[7:0].
  - lh (001): sign-extend sh[15:0].
  - lhu (101): zero-extend sh[15:0].
  - lw (010): dmem_rdata, unshifted.
  - Any other code: raw dmem_rdata.
- Misaligned halfword (bit_shift = 3): no exception. Bytes are truncated by the shift: store mask 4'b1000; load high half reads as 0, then extension is applied.
- dmem_address = addr_aligned as latched.
- All dmem_* outputs are registered; stall is combinational from the state plus request qualifiers.

Decomposition:
- Shared package (rv32i_types): lsu_state_t enum {IDLE, BUSY, DONE}; reuse the existing load_funct3_t and store_funct3_t enums.
- One combinational sub-module, load_formatter: inputs dmem_rdata, bit_shift, funct3; output formatted word.

Test Plan:
- lb, bit_shift=2, dmem_rdata=32'h0080_1234, resp after 2 cycles -> dmem_read high for 3 cycles, load_data=32'hFFFF_FF80, load_valid 1 pulse, stall low only in DONE.
- lhu, bit_shift=2, dmem_rdata=32'h8001_5555 -> load_data=32'h0000_8001; lw with the same data -> load_data=32'h8001_5555.
- sb, bit_shift=1, store_data=32'h0000_00AB, byte_enable=4'b0010 -> dmem_write=1, dmem_wdata=32'h0000_AB00, dmem_mbe=4'b0010, address held until resp, no load_valid.
- Back-to-back load then store, resp in 1 cycle each -> each op takes 3 cycles, stall pattern 1,1,0 per op, no request issued during DONE.
- rst asserted in BUSY while dmem_read=1 -> next cycle dmem_read=0, state IDLE, load_valid never pulses; a later dmem_resp is ignored.
- Spurious dmem_resp in IDLE with req_valid=0 -> no state change, load_data unchanged, stall=0.
